// File: rtl/serial_pkg.sv
// Shared constants, drain-state encoding and a clog2 helper for the serial line buffer.
package serial_pkg;
  localparam logic [7:0] SERIAL_CR = 8'h0D;
  localparam logic [7:0] SERIAL_LF = 8'h0A;
  localparam logic       MODE_BYTE = 1'b0;
  localparam logic       MODE_LINE = 1'b1;

  typedef enum logic [1:0] {DRAIN_IDLE, DRAIN_SEND, DRAIN_WAIT} drain_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/serial_line_buffer_fifo_sync.sv
// Synchronous FIFO: registered level, combinational head-of-queue read, one cycle write-to-visible.
// Writes when full and reads when empty are ignored; the caller decides what a refused write means.
module fifo_sync
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [clog2(DEPTH):0]  level,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_wr) - LW'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/serial_line_buffer.sv
// RX-to-TX byte buffer with optional line hold, sticky overflow and fill level.
// rx_strobe to tx_strobe is two cycles when idle; tx_ready gates pops, at most one pop every other cycle.
module serial_line_buffer
  import serial_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 16,
  parameter logic [WIDTH-1:0] TERMINATOR = WIDTH'(SERIAL_CR)
) (
  input  logic                  mclk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      rx_data,
  input  logic                  rx_strobe,
  input  logic                  tx_ready,
  output logic [WIDTH-1:0]      tx_data,
  output logic                  tx_strobe,
  input  logic                  line_mode,
  input  logic                  clear_overflow,
  output logic                  overflow,
  output logic [clog2(DEPTH):0] level
);
  localparam int LW = clog2(DEPTH) + 1;

  drain_state_t     state;
  logic [LW-1:0]    lines_pending;
  logic             flush;
  logic [WIDTH-1:0] rd_data;
  logic             full;
  logic             empty;
  logic             accept;
  logic             release_ok;
  logic             can_pop;
  logic             pop;
  logic             term_in;
  logic             term_out;

  assign accept     = rx_strobe && !full;
  assign release_ok = (line_mode == MODE_BYTE) || (lines_pending != '0) || flush;
  assign can_pop    = !empty && release_ok;
  // Never pop in the strobe cycle: tx_ready only drops one cycle after the transmitter loads.
  assign pop        = can_pop && tx_ready && (state != DRAIN_SEND);
  assign term_in    = accept && (rx_data == TERMINATOR);
  assign term_out   = pop && (rd_data == TERMINATOR);

  fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (mclk),
    .reset   (reset),
    .wr_en   (rx_strobe),
    .wr_data (rx_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge mclk) begin
    if (reset) begin
      state         <= DRAIN_IDLE;
      tx_strobe     <= 1'b0;
      tx_data       <= '0;
      overflow      <= 1'b0;
      lines_pending <= '0;
      flush         <= 1'b0;
    end else begin
      tx_strobe <= pop;
      if (pop) tx_data <= rd_data;

      if (pop)          state <= DRAIN_SEND;
      else if (can_pop) state <= DRAIN_WAIT;
      else              state <= DRAIN_IDLE;

      if (rx_strobe && full)  overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;

      if (term_in && !term_out)      lines_pending <= lines_pending + LW'(1);
      else if (!term_in && term_out) lines_pending <= lines_pending - LW'(1);

      // A full buffer with no complete line would never drain in line mode.
      if (line_mode == MODE_LINE && full && lines_pending == '0) flush <= 1'b1;
      else if (empty)                                           flush <= 1'b0;
    end
  end
endmodule

// File: tb/tb_serial_line_buffer.sv
// Bench for serial_line_buffer: vector table, directed corner sequences, randomized run against a queue model.
module tb_serial_line_buffer;
  import serial_pkg::*;

  logic       mclk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_strobe;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_strobe;
  logic       line_mode;
  logic       clear_overflow;
  logic       overflow;
  logic [4:0] level;

  int errors = 0;
  int checks = 0;
  int b2b = 0;
  logic prev_s = 1'b0;

  serial_line_buffer #(.WIDTH(8), .DEPTH(16), .TERMINATOR(8'h0D)) dut (
    .mclk           (mclk),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_strobe      (rx_strobe),
    .tx_ready       (tx_ready),
    .tx_data        (tx_data),
    .tx_strobe      (tx_strobe),
    .line_mode      (line_mode),
    .clear_overflow (clear_overflow),
    .overflow       (overflow),
    .level          (level)
  );

  always #5 mclk = ~mclk;

  always @(negedge mclk) begin
    if (tx_strobe && prev_s) b2b <= b2b + 1;
    prev_s <= tx_strobe;
  end

  typedef struct {
    logic       rst, rx;
    logic [7:0] d;
    logic       rdy, lm, clr;
    logic       es;
    logic [7:0] ed;
    logic [4:0] el;
    logic       eo;
  } vec_t;
  vec_t vt[16];

  // Reference model: the buffer is a queue; pending lines are the terminators currently in it.
  logic [7:0] mq[$];
  bit         m_ovf, m_flush, m_strobe, m_full, m_rel, m_pop;
  logic [7:0] m_data;
  int         m_lines;
  int         p_rx[8]  = '{30, 70, 90, 50, 80, 60, 95, 40};
  int         p_rdy[8] = '{90, 40, 20, 70, 30, 60, 10, 80};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    rx_strobe = 1'b1;
    rx_data   = d;
    tick();
    rx_strobe = 1'b0;
  endtask

  task automatic get_byte(input string name, input logic [7:0] exp, input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (tx_strobe) got = 1'b1;
    end
    chk({name, " strobe seen"}, 32'(got), 32'd1);
    if (got) chk({name, " data"}, 32'(tx_data), 32'(exp));
  endtask

  task automatic no_strobe(input string name, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (tx_strobe) cnt++;
    end
    chk(name, cnt, 0);
  endtask

  task model_step();
    if (reset) begin
      mq.delete();
      m_ovf = 0; m_flush = 0; m_strobe = 0; m_data = 8'h00;
    end else begin
      m_lines = 0;
      foreach (mq[i]) if (mq[i] == SERIAL_CR) m_lines++;
      m_full = (mq.size() == 16);
      m_rel  = (line_mode == MODE_BYTE) || (m_lines > 0) || m_flush;
      m_pop  = (mq.size() > 0) && m_rel && tx_ready && !m_strobe;
      if (line_mode == MODE_LINE && m_full && m_lines == 0) m_flush = 1;
      else if (mq.size() == 0)                              m_flush = 0;
      if (rx_strobe && m_full) m_ovf = 1;
      else if (clear_overflow) m_ovf = 0;
      m_strobe = m_pop;
      if (m_pop) m_data = mq.pop_front();
      if (rx_strobe && !m_full) mq.push_back(rx_data);
    end
  endtask

  initial begin
    bit seen;
    reset = 1'b1; rx_strobe = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    line_mode = MODE_BYTE; clear_overflow = 1'b0;

    //          rst rx  d      rdy lm clr | es  ed     el     eo
    vt[0]  = '{1, 0, 8'h00, 0, 0, 0,  0, 8'h00, 5'd0, 0};
    vt[1]  = '{0, 1, 8'h41, 1, 0, 0,  0, 8'h00, 5'd1, 0};
    vt[2]  = '{0, 0, 8'h00, 1, 0, 0,  1, 8'h41, 5'd0, 0};
    vt[3]  = '{0, 0, 8'h00, 1, 0, 0,  0, 8'h41, 5'd0, 0};
    vt[4]  = '{0, 1, 8'h61, 1, 1, 0,  0, 8'h41, 5'd1, 0};
    vt[5]  = '{0, 1, 8'h0D, 1, 1, 0,  0, 8'h41, 5'd2, 0};
    vt[6]  = '{0, 0, 8'h00, 1, 1, 0,  1, 8'h61, 5'd1, 0};
    vt[7]  = '{0, 0, 8'h00, 1, 1, 0,  0, 8'h61, 5'd1, 0};
    vt[8]  = '{0, 0, 8'h00, 1, 1, 0,  1, 8'h0D, 5'd0, 0};
    vt[9]  = '{0, 1, 8'h62, 1, 1, 0,  0, 8'h0D, 5'd1, 0};
    vt[10] = '{0, 0, 8'h00, 1, 1, 0,  0, 8'h0D, 5'd1, 0};
    vt[11] = '{0, 0, 8'h00, 0, 0, 0,  0, 8'h0D, 5'd1, 0};
    vt[12] = '{0, 0, 8'h00, 1, 0, 0,  1, 8'h62, 5'd0, 0};
    vt[13] = '{0, 1, 8'h63, 0, 0, 1,  0, 8'h62, 5'd1, 0};
    vt[14] = '{0, 0, 8'h00, 1, 0, 0,  1, 8'h63, 5'd0, 0};
    vt[15] = '{1, 1, 8'h77, 1, 0, 0,  0, 8'h00, 5'd0, 0};

    tick(); tick();
    for (int i = 0; i < 16; i++) begin
      reset = vt[i].rst; rx_strobe = vt[i].rx; rx_data = vt[i].d;
      tx_ready = vt[i].rdy; line_mode = vt[i].lm; clear_overflow = vt[i].clr;
      tick();
      chk($sformatf("vec%0d tx_strobe", i), 32'(tx_strobe), 32'(vt[i].es));
      chk($sformatf("vec%0d tx_data", i),   32'(tx_data),   32'(vt[i].ed));
      chk($sformatf("vec%0d level", i),     32'(level),     32'(vt[i].el));
      chk($sformatf("vec%0d overflow", i),  32'(overflow),  32'(vt[i].eo));
    end
    reset = 1'b0; rx_strobe = 1'b0; clear_overflow = 1'b0;

    // Line mode holds "abc" until the terminator, then releases in order.
    line_mode = MODE_LINE; tx_ready = 1'b1;
    write_byte(8'h61); write_byte(8'h62); write_byte(8'h63);
    no_strobe("line hold abc", 50);
    chk("line hold level", 32'(level), 32'd3);
    write_byte(8'h0D);
    get_byte("line a", 8'h61, 10);
    get_byte("line b", 8'h62, 10);
    get_byte("line c", 8'h63, 10);
    get_byte("line cr", 8'h0D, 10);
    chk("line drained level", 32'(level), 32'd0);
    write_byte(8'h78);
    no_strobe("no stale line count", 20);
    line_mode = MODE_BYTE;
    get_byte("mode switch release", 8'h78, 5);

    // Overflow: fill, then a drop coinciding with a pop and a clear pulse.
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    chk("full level", 32'(level), 32'd16);
    chk("full no overflow yet", 32'(overflow), 32'd0);
    rx_strobe = 1'b1; rx_data = 8'h10; clear_overflow = 1'b1; tx_ready = 1'b1;
    tick();
    rx_strobe = 1'b0; clear_overflow = 1'b0;
    chk("drop beats clear", 32'(overflow), 32'd1);
    chk("drop with pop level", 32'(level), 32'd15);
    chk("drop with pop strobe", 32'(tx_strobe), 32'd1);
    chk("drop with pop data", 32'(tx_data), 32'd0);
    for (int i = 1; i < 16; i++) get_byte($sformatf("drain %0d", i), 8'(i), 5);
    no_strobe("dropped byte absent", 10);
    chk("overflow sticky", 32'(overflow), 32'd1);
    clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
    chk("overflow cleared", 32'(overflow), 32'd0);

    // Flush: line mode with a full buffer and no terminator must still drain.
    line_mode = MODE_LINE; tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) write_byte(8'h20 + 8'(i));
    chk("flush fill level", 32'(level), 32'd16);
    for (int i = 0; i < 16; i++) get_byte($sformatf("flush %0d", i), 8'h20 + 8'(i), 10);
    chk("flush drained level", 32'(level), 32'd0);
    write_byte(8'h41);
    no_strobe("flush cleared holds", 20);
    line_mode = MODE_BYTE;
    get_byte("flush leftover", 8'h41, 5);

    // Reset during a strobe cycle discards everything, including overflow.
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) write_byte(8'h90 + 8'(i));
    chk("pre-reset overflow", 32'(overflow), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tx_ready = ~tx_ready;
      tick();
      if (tx_strobe) seen = 1'b1;
    end
    chk("pre-reset strobe seen", 32'(seen), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("reset strobe", 32'(tx_strobe), 32'd0);
    chk("reset level", 32'(level), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset tx_data", 32'(tx_data), 32'd0);
    tx_ready = 1'b1;
    write_byte(8'h55);
    get_byte("post-reset byte", 8'h55, 5);
    no_strobe("post-reset no stale", 10);
    chk("post-reset level", 32'(level), 32'd0);

    // Randomized traffic against the queue model.
    reset = 1'b1; tick(); reset = 1'b0;
    mq.delete(); m_ovf = 0; m_flush = 0; m_strobe = 0; m_data = 8'h00;
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 250; c++) begin
        reset     = ($urandom_range(0, 199) == 0);
        rx_strobe = ($urandom_range(0, 99) < p_rx[s]);
        if ($urandom_range(0, 99) < 15)     rx_data = SERIAL_CR;
        else if ($urandom_range(0, 9) == 0) rx_data = SERIAL_LF;
        else                                rx_data = 8'($urandom_range(0, 255));
        tx_ready = ($urandom_range(0, 99) < p_rdy[s]);
        if (s % 3 == 0)                      line_mode = MODE_BYTE;
        else if (s % 3 == 1)                 line_mode = MODE_LINE;
        else if ($urandom_range(0, 19) == 0) line_mode = ~line_mode;
        clear_overflow = ($urandom_range(0, 19) == 0);
        model_step();
        tick();
        chk($sformatf("rnd s%0d c%0d tx_strobe", s, c), 32'(tx_strobe), 32'(m_strobe));
        chk($sformatf("rnd s%0d c%0d tx_data", s, c),   32'(tx_data),   32'(m_data));
        chk($sformatf("rnd s%0d c%0d level", s, c),     32'(level),     32'(mq.size()));
        chk($sformatf("rnd s%0d c%0d overflow", s, c),  32'(overflow),  32'(m_ovf));
      end
    end
    reset = 1'b0; rx_strobe = 1'b0; clear_overflow = 1'b0;
    tick();
    chk("no back-to-back strobes", b2b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
